// File: rtl/prog_mem_arbiter_if.sv
// Wishbone-style bus bundle shared by the fetch port, the data/debug port
// and the program memory.
interface wb_bus;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic        ack;
   logic        err;

   modport master (output addr, wdata, sel, we, stb, input rdata, ack, err);
   modport slave  (input addr, wdata, sel, we, stb, output rdata, ack, err);
endinterface

// File: rtl/prog_mem_arbiter.sv
// Round-robin two-master arbiter for the single-ported program memory, with a
// forced idle cycle between transactions and a watchdog on stalled grants.
module prog_mem_arbiter #(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic  clk_in,
   input  logic  reset_in,
   wb_bus.slave  m0_slave,
   wb_bus.slave  m1_slave,
   wb_bus.master mem_master,
   output logic  timeout_pulse
);

   localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntLast = (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TOUT} state_t;

   state_t          state;
   state_t          state_nxt;
   logic            last;
   logic [CntW-1:0] cnt;
   logic            owner;
   logic            cur_stb;
   logic            done;
   logic            expire;
   logic            granted;

   always_comb begin
      granted = (state == GRANT0) || (state == GRANT1);
      owner   = (state == GRANT1);
      cur_stb = owner ? m1_slave.stb : m0_slave.stb;
      done    = mem_master.ack || mem_master.err || !cur_stb;
      expire  = (TimeoutCycles != 0) && (cnt == CntLast);
   end

   // last is written on every exit from a grant, so in TOUT it already names
   // the timed-out master and steers its err.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (granted) begin
            cnt <= cnt + CntW'(1);
            if (state_nxt != state) last <= owner;
         end else begin
            cnt <= '0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_slave.stb && m1_slave.stb) state_nxt = last ? GRANT0 : GRANT1;
            else if (m0_slave.stb)            state_nxt = GRANT0;
            else if (m1_slave.stb)            state_nxt = GRANT1;
         end
         GRANT0, GRANT1: begin
            if (done)        state_nxt = IDLE;
            else if (expire) state_nxt = TOUT;
         end
         TOUT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_master.addr  = '0;
      mem_master.wdata = '0;
      mem_master.sel   = '0;
      mem_master.we    = 1'b0;
      mem_master.stb   = 1'b0;
      m0_slave.ack     = 1'b0;
      m0_slave.err     = 1'b0;
      m1_slave.ack     = 1'b0;
      m1_slave.err     = 1'b0;
      m0_slave.rdata   = mem_master.rdata;
      m1_slave.rdata   = mem_master.rdata;
      timeout_pulse    = 1'b0;
      case (state)
         GRANT0: begin
            mem_master.addr  = m0_slave.addr;
            mem_master.wdata = m0_slave.wdata;
            mem_master.sel   = m0_slave.sel;
            mem_master.we    = m0_slave.we;
            mem_master.stb   = m0_slave.stb;
            m0_slave.ack     = mem_master.ack;
            m0_slave.err     = mem_master.err;
         end
         GRANT1: begin
            mem_master.addr  = m1_slave.addr;
            mem_master.wdata = m1_slave.wdata;
            mem_master.sel   = m1_slave.sel;
            mem_master.we    = m1_slave.we;
            mem_master.stb   = m1_slave.stb;
            m1_slave.ack     = mem_master.ack;
            m1_slave.err     = mem_master.err;
         end
         TOUT: begin
            timeout_pulse = 1'b1;
            if (last) m1_slave.err = 1'b1;
            else      m0_slave.err = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: directed scenarios followed by random traffic,
// all cycles checked against a cycle-level arbitration model.
module tb_prog_mem_arbiter;
   localparam int unsigned TO = 4;

   logic clk_in = 1'b0;
   logic reset_in;
   logic timeout_pulse;

   wb_bus m0_bus ();
   wb_bus m1_bus ();
   wb_bus mem_bus ();

   prog_mem_arbiter #(.TimeoutCycles(TO)) dut (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .m0_slave     (m0_bus),
      .m1_slave     (m1_bus),
      .mem_master   (mem_bus),
      .timeout_pulse(timeout_pulse)
   );

   always #5 clk_in = ~clk_in;

   // Program memory: read-only, acks one cycle after stb, errs at once on
   // writes and misaligned addresses; noack makes it stall forever.
   logic [31:0] rom [16];
   logic        ackq;
   logic        noack;
   assign mem_bus.rdata = rom[mem_bus.addr[5:2]];
   assign mem_bus.err   = mem_bus.stb && ((mem_bus.addr[1:0] != 2'b00) || mem_bus.we);
   assign mem_bus.ack   = mem_bus.stb && ackq && !mem_bus.err;
   always @(posedge clk_in) ackq <= !reset_in && mem_bus.stb && !ackq && !noack;

   int total = 0;
   int bad   = 0;

   logic        act [2];
   logic [31:0] cur_addr [2];
   logic        cur_we [2];
   logic [31:0] cur_wdata [2];

   int srv, tout, lastm, age;

   logic        s_ack [2];
   logic        s_err [2];
   logic [31:0] s_rd [2];
   logic        s_act [2];
   logic        s_mstb, s_mwe, s_tp, s_rst, s_mack, s_merr;
   logic [31:0] s_maddr, s_mwdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic drive();
      m0_bus.stb = act[0]; m0_bus.addr = cur_addr[0]; m0_bus.we = cur_we[0];
      m0_bus.wdata = cur_wdata[0]; m0_bus.sel = 4'hF;
      m1_bus.stb = act[1]; m1_bus.addr = cur_addr[1]; m1_bus.we = cur_we[1];
      m1_bus.wdata = cur_wdata[1]; m1_bus.sel = 4'hF;
   endtask

   task automatic issue(input int m, input logic [31:0] a, input logic w);
      act[m] = 1'b1; cur_addr[m] = a; cur_we[m] = w; cur_wdata[m] = $urandom;
      drive();
   endtask

   // One clock: check this cycle's outputs against the model, advance the
   // model across the edge, then let each master retire on ack/err.
   task automatic cycle();
      logic exp_stb;
      @(negedge clk_in);
      s_ack[0] = m0_bus.ack; s_err[0] = m0_bus.err; s_rd[0] = m0_bus.rdata;
      s_ack[1] = m1_bus.ack; s_err[1] = m1_bus.err; s_rd[1] = m1_bus.rdata;
      s_act[0] = act[0]; s_act[1] = act[1];
      s_mstb = mem_bus.stb; s_maddr = mem_bus.addr; s_mwe = mem_bus.we;
      s_mwdata = mem_bus.wdata; s_mack = mem_bus.ack; s_merr = mem_bus.err;
      s_tp = timeout_pulse; s_rst = reset_in;

      exp_stb = (srv >= 0) ? act[srv] : 1'b0;
      chk1("mem_stb", s_mstb, exp_stb);
      if (exp_stb && s_mstb) begin
         chk("mem_addr", s_maddr, cur_addr[srv]);
         chk1("mem_we", s_mwe, cur_we[srv]);
         chk("mem_wdata", s_mwdata, cur_wdata[srv]);
      end
      for (int m = 0; m < 2; m++) begin
         chk1($sformatf("m%0d_ack", m), s_ack[m], (srv == m) && s_mack);
         chk1($sformatf("m%0d_err", m), s_err[m], ((srv == m) && s_merr) || (tout == m));
         if ((srv == m) && s_mack) chk($sformatf("m%0d_rdata", m), s_rd[m], rom[cur_addr[m][5:2]]);
      end
      chk1("timeout_pulse", s_tp, tout >= 0);

      @(posedge clk_in);
      if (s_rst) begin
         srv = -1; tout = -1; lastm = 1; age = 0;
      end else if (tout >= 0) begin
         lastm = tout; tout = -1;
      end else if (srv >= 0) begin
         if (s_mack || s_merr || !s_act[srv]) begin
            lastm = srv; srv = -1;
         end else if (TO != 0 && age == int'(TO) - 1) begin
            tout = srv; srv = -1;
         end else begin
            age++;
         end
      end else begin
         if (s_act[0] && s_act[1]) srv = 1 - lastm;
         else if (s_act[0])        srv = 0;
         else if (s_act[1])        srv = 1;
         age = 0;
      end
      #1;
      for (int m = 0; m < 2; m++)
         if (act[m] && (s_ack[m] || s_err[m])) act[m] = 1'b0;
      drive();
   endtask

   initial begin
      int prev_start, exp_owner, grants;
      logic prev_stb;
      logic [31:0] a;

      for (int i = 0; i < 16; i++) rom[i] = $urandom;
      rom[1] = 32'hDEADBEEF;
      for (int m = 0; m < 2; m++) begin
         act[m] = 1'b0; cur_addr[m] = '0; cur_we[m] = 1'b0; cur_wdata[m] = '0;
      end
      noack = 1'b0; reset_in = 1'b1;
      srv = -1; tout = -1; lastm = 1; age = 0;
      drive();
      cycle(); cycle();
      chk1("reset_stb", s_mstb, 1'b0);
      chk1("reset_tp", s_tp, 1'b0);
      reset_in = 1'b0;

      // single fetch
      issue(0, 32'h4, 1'b0);
      cycle(); chk1("fetch_c0_stb", s_mstb, 1'b0);
      cycle(); chk1("fetch_c1_stb", s_mstb, 1'b1);
      cycle(); chk1("fetch_c2_ack", s_ack[0], 1'b1);
      chk("fetch_c2_rdata", s_rd[0], 32'hDEADBEEF);
      chk1("fetch_c2_m1ack", s_ack[1], 1'b0);
      cycle(); chk1("fetch_c3_idle", s_mstb, 1'b0);

      // simultaneous request right after reset: m0 first
      reset_in = 1'b1; cycle(); reset_in = 1'b0;
      issue(0, 32'h0, 1'b0); issue(1, 32'hC, 1'b0);
      cycle();
      cycle(); chk1("sim_c1_stb", s_mstb, 1'b1); chk("sim_c1_addr", s_maddr, 32'h0);
      cycle(); chk1("sim_c2_m0ack", s_ack[0], 1'b1);
      cycle(); chk1("sim_c3_gap", s_mstb, 1'b0);
      cycle(); chk1("sim_c4_stb", s_mstb, 1'b1); chk("sim_c4_addr", s_maddr, 32'hC);
      cycle(); chk1("sim_c5_m1ack", s_ack[1], 1'b1); chk("sim_c5_rdata", s_rd[1], rom[3]);
      cycle();

      // continuous contention: alternate owners every 3 cycles
      prev_start = -1; exp_owner = 0; grants = 0; prev_stb = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (!act[0]) issue(0, 32'h10, 1'b0);
         if (!act[1]) issue(1, 32'h20, 1'b0);
         cycle();
         if (s_mstb && !prev_stb) begin
            chk("cont_owner", s_maddr, (exp_owner == 1) ? 32'h20 : 32'h10);
            if (prev_start >= 0) chk("cont_spacing", 32'(i - prev_start), 32'd3);
            prev_start = i; exp_owner = 1 - exp_owner; grants++;
         end
         prev_stb = s_mstb;
      end
      chk("cont_grants", 32'(grants), 32'd5);
      repeat (8) cycle();

      // error pass-through on a write, then m0 wins the next tie
      issue(1, 32'h8, 1'b1);
      cycle();
      cycle(); chk1("err_c1_err", s_err[1], 1'b1); chk1("err_c1_ack", s_ack[1], 1'b0);
      cycle(); chk1("err_c2_idle", s_mstb, 1'b0);
      issue(0, 32'h14, 1'b0); issue(1, 32'h18, 1'b0);
      cycle();
      cycle(); chk("err_tie_addr", s_maddr, 32'h14);
      repeat (6) cycle();

      // watchdog on a stalled memory, then a pending m1 is served
      noack = 1'b1;
      issue(0, 32'h0, 1'b0);
      cycle();
      for (int k = 1; k <= 4; k++) begin
         cycle();
         chk1($sformatf("wd_c%0d_stb", k), s_mstb, 1'b1);
         chk1($sformatf("wd_c%0d_err", k), s_err[0], 1'b0);
         if (k == 2) issue(1, 32'h24, 1'b0);
      end
      cycle(); chk1("wd_c5_err", s_err[0], 1'b1); chk1("wd_c5_tp", s_tp, 1'b1);
      chk1("wd_c5_stb", s_mstb, 1'b0);
      noack = 1'b0;
      cycle(); chk1("wd_c6_stb", s_mstb, 1'b0); chk1("wd_c6_tp", s_tp, 1'b0);
      cycle(); chk1("wd_c7_stb", s_mstb, 1'b1); chk("wd_c7_addr", s_maddr, 32'h24);
      cycle(); chk1("wd_c8_m1ack", s_ack[1], 1'b1);
      repeat (3) cycle();

      // reset during GRANT1 in the cycle the ack is due
      issue(1, 32'h4, 1'b0);
      cycle();
      cycle(); chk1("rst_c1_stb", s_mstb, 1'b1);
      reset_in = 1'b1;
      cycle();
      reset_in = 1'b0;
      act[1] = 1'b0; drive();
      cycle();
      chk1("rst_c3_stb", s_mstb, 1'b0);
      chk1("rst_c3_ack0", s_ack[0], 1'b0); chk1("rst_c3_ack1", s_ack[1], 1'b0);
      chk1("rst_c3_err0", s_err[0], 1'b0); chk1("rst_c3_err1", s_err[1], 1'b0);
      issue(0, 32'h28, 1'b0); issue(1, 32'h2C, 1'b0);
      cycle();
      cycle(); chk("rst_tie_addr", s_maddr, 32'h28);
      repeat (6) cycle();

      // random traffic with aborts, stalls and occasional resets
      for (int i = 0; i < 800; i++) begin
         if (i % 50 == 0) noack = ($urandom_range(0, 3) == 0);
         reset_in = ($urandom_range(0, 299) == 0);
         for (int m = 0; m < 2; m++) begin
            if (act[m]) begin
               if ($urandom_range(0, 24) == 0) act[m] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
               if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
               issue(m, a, $urandom_range(0, 7) == 0);
            end
         end
         drive();
         cycle();
      end
      reset_in = 1'b0;
      noack = 1'b0;
      act[0] = 1'b0; act[1] = 1'b0; drive();
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
